// File: rtl/dmem_nic_resp.sv
// Data-memory responder for one ring node: local SRAM plus a memory-mapped
// TX/RX FIFO window onto the ring router, with a sticky-error status word.
module dmem_nic_resp #(
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8,
  parameter int FIFO_D = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] addr_in,
  input  logic [0:63] d_in,
  input  logic        memEn,
  input  logic        memWrEn,
  output logic [0:63] d_out,
  output logic        net_so,
  input  logic        net_ro,
  output logic [0:63] net_do,
  input  logic        net_si,
  output logic        net_ri,
  input  logic [0:63] net_di
);

  localparam int PW = $clog2(FIFO_D);
  localparam int CW = PW + 1;

  // Ring handshake: a word moves on a rising edge where valid (net_so/net_si)
  // and ready (net_ro/net_ri) are both high; valid never waits on ready.

  logic [0:63]   mem [DEPTH];
  logic [0:63]   tx_mem [FIFO_D];
  logic [0:63]   rx_mem [FIFO_D];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_ovf, rx_unf;

  logic             is_mmio, ld, st;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  assign is_mmio     = addr_in[16];
  assign off         = addr_in[30:31];
  assign idx         = addr_in[32-IDX_W:31];
  assign ld          = memEn & ~memWrEn;
  assign st          = memEn & memWrEn;
  assign unused_addr = ^addr_in;

  logic tx_full, rx_full, rx_valid;
  logic tx_wr_hit, tx_push, tx_pop, tx_ovf_set;
  logic rx_rd_hit, rx_push, rx_pop, rx_unf_set, stat_rd;

  assign tx_full  = (tx_cnt == CW'(FIFO_D));
  assign rx_full  = (rx_cnt == CW'(FIFO_D));
  assign rx_valid = (rx_cnt != '0);

  assign tx_wr_hit  = st & is_mmio & (off == 2'd0);
  assign tx_push    = tx_wr_hit & ~tx_full;
  assign tx_ovf_set = tx_wr_hit & tx_full;
  assign tx_pop     = net_so & net_ro;

  assign rx_rd_hit  = ld & is_mmio & (off == 2'd1);
  assign rx_pop     = rx_rd_hit & rx_valid;
  assign rx_unf_set = rx_rd_hit & ~rx_valid;
  assign rx_push    = net_si & net_ri;
  assign stat_rd    = ld & is_mmio & (off == 2'd2);

  assign net_so = (tx_cnt != '0);
  assign net_do = tx_mem[tx_rd];
  assign net_ri = ~rx_full;

  // Occupancy field is 3 bits wide and saturates so deeper FIFOs still fit.
  logic [2:0]  rx_occ;
  logic [0:63] status;
  always_comb begin
    rx_occ = 3'd7;
    if (int'(rx_cnt) <= 7) rx_occ = 3'(rx_cnt);
  end
  assign status = {56'b0, rx_occ, tx_full, rx_valid, rx_unf, tx_ovf, 1'b0};

  logic [0:63] rdata;
  always_comb begin
    rdata = '0;
    if (!is_mmio) begin
      rdata = mem[idx];
    end else begin
      case (off)
        2'd1:    rdata = rx_valid ? rx_mem[rx_rd] : '0;
        2'd2:    rdata = status;
        default: rdata = '0;
      endcase
    end
  end

  // Storage arrays carry no reset; emptiness is tracked by the counters.
  always_ff @(posedge clk) begin
    if (st && !is_mmio) mem[idx] <= d_in;
    if (tx_push)        tx_mem[tx_wr] <= d_in;
    if (rx_push)        rx_mem[rx_wr] <= net_di;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out  <= '0;
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (ld) d_out <= rdata;
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
      // A status read and a new error cannot share an edge (one access per cycle).
      if (stat_rd) begin
        tx_ovf <= 1'b0;
        rx_unf <= 1'b0;
      end else begin
        if (tx_ovf_set) tx_ovf <= 1'b1;
        if (rx_unf_set) rx_unf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dmem_nic_resp.md
Name: dmem_nic_resp

Overview:
- Responder at the far end of the core's data-memory port (addr/d_out/memEn/memWrEn out of the core, d_in back into it).
- Serves core loads and stores from a local 64-bit SRAM array.
- Exposes a memory-mapped window onto the ring network: a TX FIFO toward the ring router, an RX FIFO from it, and a status word.
- Sits between the cmp core and the ring router in each node.

Parameters:
DEPTH, 256, number of 64-bit words in local SRAM (power of 2)
IDX_W, 8, SRAM index width = log2(DEPTH)
FIFO_D, 2, entries in each of TX and RX FIFOs (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
addr_in  input  [0:31]  word address from core; only [16:31] decoded, [0:15] ignored
d_in  input  [0:63]  store data from core
memEn  input  1  access request this cycle
memWrEn  input  1  1 = store, 0 = load; ignored unless memEn=1
d_out  output  [0:63]  load data to core, registered
net_so  output  1  TX valid toward ring
net_ro  input  1  ring ready for TX word
net_do  output  [0:63]  TX word (head of TX FIFO)
net_si  input  1  RX valid from ring
net_ri  output  1  ready to accept RX word
net_di  input  [0:63]  RX word from ring

Behaviour:
- Bit order big-endian: bit 0 = MSB, bit 63 = LSB.
- Decode on memEn=1:
  - addr_in[16]=0: SRAM, index = addr_in[32-IDX_W:31]; upper unused bits ignored (alias).
  - addr_in[16]=1: MMIO, offset = addr_in[30:31]:
    - 0 = TX_DATA (write only).
    - 1 = RX_DATA (read only).
    - 2 = STATUS (read only).
    - 3 = reserved: reads return 0, writes ignored.
- Store (memEn=1, memWrEn=1):
  - SRAM: word written at the edge.
  - TX_DATA: push d_in if TX not full at that edge; if full, drop the word and set sticky tx_ovf.
  - Writes to RX_DATA and STATUS are ignored.
- Load (memEn=1, memWrEn=0):
  - d_out updated at the next edge: 1-cycle latency, matching the core's load stall.
  - d_out holds its value until the next load.
  - Stores do not change d_out.
- SRAM load returns the pre-edge contents. A load and store in the same cycle cannot occur (single port).
- RX_DATA load:
  - If RX is non-empty: d_out = head, and the head is popped at the same edge.
  - If RX is empty: d_out = 0, no pop, set sticky rx_unf.
- STATUS load: d_out = {56'b0, count_rx[3 bits sat], tx_full, rx_valid, rx_unf, tx_ovf, 1'b0} with layout:
  - bit 63 = 0
  - bit 62 = tx_ovf
  - bit 61 = rx_unf
  - bit 60 = rx_valid (RX non-empty)
  - bit 59 = tx_full
  - bits [56:58] = RX occupancy, saturating at 7
  - all other bits 0
  - Values are sampled pre-edge.
  - A STATUS read clears tx_ovf and rx_unf at the same edge. If a new overflow or underflow occurs on that same edge, it is impossible, since only one access occurs per cycle.
- TX FIFO:
  - net_so = TX non-empty; net_do = head.
  - Pop on an edge where net_so & net_ro.
  - A push and a pop in the same cycle are both performed; fullness for the push is judged pre-edge, so a push to a full FIFO is dropped even if a pop occurs that edge.
- RX FIFO:
  - net_ri = RX not full (pre-edge).
  - Push net_di on an edge where net_si & net_ri.
  - A simultaneous push and core pop are both performed.
- FIFO storage: circular buffers, pointers wrap modulo FIFO_D, count width log2(FIFO_D)+1.
- Reset (async assert, any time including mid-transfer):
  - d_out=0; both FIFOs empty (net_so=0, net_ri=1 after reset); tx_ovf=rx_unf=0.
  - SRAM contents undefined (not cleared).
  - In-flight TX/RX words are discarded.

Test Plan:
- Store 0x0123456789ABCDEF to addr 0x0000_0005, then load addr 0x0000_0005 -> d_out=0x0123456789ABCDEF one cycle after the load; a following store leaves d_out unchanged.
- Hold net_ro=0; store 0xA, 0xB, 0xC to TX_DATA (0x0000_8000) -> net_so=1, net_do=0xA, 0xC dropped; STATUS read (0x0000_8002) gives bit59=1, bit62=1; a second STATUS read gives bit62=0.
- Release net_ro=1 -> 0xA then 0xB presented on consecutive cycles; net_so=0 after two cycles.
- Ring drives 0x11, 0x22, 0x33 with net_si=1 -> net_ri falls after 2 accepts, 0x33 held off. RX_DATA loads (0x0000_8001) return 0x11 then 0x22; 0x33 is accepted when space frees; a third load returns 0x33.
- RX_DATA load with RX empty -> d_out=0, STATUS bit61=1.
- Assert reset low while TX holds 2 words and RX holds 1 -> immediately net_so=0, d_out=0; after release net_ri=1 and STATUS reads 0.
